score_text_writer: RTL



---
 rtl/score_text_if.sv | 23 ++
 rtl/score_text_writer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/score_text_if.sv
// Text-RAM write port plus score update/blanking inputs shared by the writer and its environment.
interface score_text_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [15:0]       score;
    logic              score_valid;
    logic              vblank;
    logic              we;
    logic [ADDR_W-1:0] write_address;
    logic [7:0]        data_In;
    logic              busy;
    logic              done;

    modport master (
        input  score, score_valid, vblank,
        output we, write_address, data_In, busy, done
    );

    modport slave (
        output score, score_valid, vblank,
        input  we, write_address, data_In, busy, done
    );
endinterface

// File: rtl/score_text_writer.sv
// Writes the "SCORE" label once after reset and a five-digit decimal score on each
// update into the text RAM, only while vertical blank is asserted.
module score_text_writer #(
    parameter int unsigned       ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] LABEL_ADDR = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] DIGIT_ADDR = ADDR_W'(6),
    parameter logic [7:0]        BLANK_CHAR = 8'h20
) (
    input  logic         Clk,
    input  logic         Reset,
    score_text_if.master bus
);
    localparam int unsigned BIN_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LAST_I = 4;

    typedef enum logic [2:0] {INIT, IDLE, CONVERT, WRITE, DONE} state_t;

    state_t            state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [BIN_W-1:0]  bin, bin_d;
    logic [BCD_W-1:0]  bcd, bcd_d;
    logic              lead, lead_d;
    logic              pend, pend_d;
    logic [BIN_W-1:0]  pend_score, pend_score_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic              busy_d;
    logic              done_d;
    logic [3:0]        nib;

    function automatic logic [7:0] label_char(input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    label_char = 8'h53;
            3'd1:    label_char = 8'h43;
            3'd2:    label_char = 8'h4F;
            3'd3:    label_char = 8'h52;
            default: label_char = 8'h45;
        endcase
    endfunction

    // Double-dabble correction: nibbles >= 5 get +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int n = 0; n < 5; n++) begin
            if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    // The BCD field shifts up one digit per write, so the current digit is always the top nibble.
    assign nib = bcd[BCD_W-1 -: 4];

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        cnt_d        = cnt;
        bin_d        = bin;
        bcd_d        = bcd;
        lead_d       = lead;
        pend_d       = pend;
        pend_score_d = pend_score;
        we_d         = 1'b0;
        addr_d       = bus.write_address;
        data_d       = bus.data_In;
        done_d       = 1'b0;

        case (state)
            INIT: begin
                if (bus.vblank) begin
                    we_d   = 1'b1;
                    addr_d = LABEL_ADDR + ADDR_W'(idx);
                    data_d = label_char(idx);
                    if (idx == IDX_W'(LAST_I)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            IDLE: begin
                if (pend && bus.vblank) begin
                    bin_d   = pend_score;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {dabble_adjust(bcd), bin} << 1;
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    idx_d   = '0;
                    lead_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.vblank) begin
                    we_d   = 1'b1;
                    addr_d = DIGIT_ADDR + ADDR_W'(idx);
                    if (lead && nib == 4'd0 && idx != IDX_W'(LAST_I)) data_d = BLANK_CHAR;
                    else                                              data_d = 8'h30 + 8'(nib);
                    if (nib != 4'd0) lead_d = 1'b0;
                    bcd_d = bcd << 4;
                    if (idx == IDX_W'(LAST_I)) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase

        // A fresh request always overrides, including the edge that consumes the old one.
        if (bus.score_valid) begin
            pend_d       = 1'b1;
            pend_score_d = bus.score;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state             <= INIT;
            idx               <= '0;
            cnt               <= '0;
            bin               <= '0;
            bcd               <= '0;
            lead              <= 1'b0;
            pend              <= 1'b0;
            pend_score        <= '0;
            bus.we            <= 1'b0;
            bus.write_address <= '0;
            bus.data_In       <= '0;
            bus.busy          <= 1'b1;
            bus.done          <= 1'b0;
        end else begin
            state             <= state_d;
            idx               <= idx_d;
            cnt               <= cnt_d;
            bin               <= bin_d;
            bcd               <= bcd_d;
            lead              <= lead_d;
            pend              <= pend_d;
            pend_score        <= pend_score_d;
            bus.we            <= we_d;
            bus.write_address <= addr_d;
            bus.data_In       <= data_d;
            bus.busy          <= busy_d;
            bus.done          <= done_d;
        end
    end
endmodule
